// File: rtl/mips_cpu_state_controller_if.sv
// Bus between the multi-cycle sequencer and the datapath: decoded IR fields and
// memory status in, state plus datapath enables out.
interface mips_cpu_state_controller_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [31:0] next_pc;
  logic        mem_waitrequest;
  logic [2:0]  state;
  logic        ir_enable;
  logic        mem_read;
  logic        mem_write;
  logic        pc_enable;
  logic        regfile_we;
  logic        active;
  logic [31:0] cycle_count;

  // Datapath side: supplies IR fields and memory status, consumes enables.
  modport master (
    output opcode, funct, rt, next_pc, mem_waitrequest,
    input  state, ir_enable, mem_read, mem_write, pc_enable, regfile_we,
    input  active, cycle_count
  );

  // Sequencer side.
  modport slave (
    input  opcode, funct, rt, next_pc, mem_waitrequest,
    output state, ir_enable, mem_read, mem_write, pc_enable, regfile_we,
    output active, cycle_count
  );
endinterface

// File: rtl/mips_cpu_state_controller.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WRITEBACK/HALTED driving datapath enables.
// Optional cycle counter enabled by defining MIPS_CPU_CYCLE_COUNT_EN.
module mips_cpu_state_controller #(
  parameter logic [31:0] HALT_PC = 32'h0000_0000
) (
  input logic                          clk,
  input logic                          reset,
  mips_cpu_state_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXEC      = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    HALTED    = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   active_q, active_d;

  logic   is_load;
  logic   is_store;
  logic   writes_reg;
  logic   ir_enable;
  logic   mem_read;
  logic   mem_write;
  logic   pc_enable;
  logic   regfile_we;

  always_comb begin
    is_load = 1'b0;
    case (bus.opcode)
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: is_load = 1'b1;
      default:                                         is_load = 1'b0;
    endcase
  end

  always_comb begin
    is_store = 1'b0;
    case (bus.opcode)
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: is_store = 1'b1;
      default:                           is_store = 1'b0;
    endcase
  end

  // R-type writes rd except jump-register, mthi/mtlo and mult/div family.
  always_comb begin
    writes_reg = 1'b0;
    case (bus.opcode)
      6'h00: begin
        case (bus.funct)
          6'h08, 6'h11, 6'h13,
          6'h18, 6'h19, 6'h1A, 6'h1B: writes_reg = 1'b0;
          default:                    writes_reg = 1'b1;
        endcase
      end
      6'h01:                             writes_reg = bus.rt[4];
      6'h03:                             writes_reg = 1'b1;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F:        writes_reg = 1'b1;
      6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26:               writes_reg = 1'b1;
      default:                           writes_reg = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ir_enable  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    pc_enable  = 1'b0;
    regfile_we = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        ir_enable = !bus.mem_waitrequest;
        if (!bus.mem_waitrequest) begin
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = EXEC;
      end
      EXEC: begin
        if (is_load || is_store) begin
          state_d = MEM;
        end else begin
          state_d = WRITEBACK;
        end
      end
      MEM: begin
        // Loads and stores are disjoint opcode sets, so at most one strobe fires.
        mem_read  = is_load;
        mem_write = is_store;
        if (!bus.mem_waitrequest) begin
          state_d = WRITEBACK;
        end
      end
      WRITEBACK: begin
        pc_enable  = 1'b1;
        regfile_we = writes_reg;
        if (bus.next_pc == HALT_PC) begin
          state_d = HALTED;
        end else begin
          state_d = FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign active_d = (state_d != HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      active_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
    end
  end

`ifdef MIPS_CPU_CYCLE_COUNT_EN
  logic [31:0] cycle_count_q, cycle_count_d;

  always_comb begin
    cycle_count_d = cycle_count_q;
    if (active_q && (state_q != HALTED)) begin
      cycle_count_d = cycle_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count_q <= 32'h0;
    end else begin
      cycle_count_q <= cycle_count_d;
    end
  end

  assign bus.cycle_count = cycle_count_q;
`else
  assign bus.cycle_count = 32'h0;
`endif

  assign bus.state      = state_q;
  assign bus.active     = active_q;
  assign bus.ir_enable  = ir_enable;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.pc_enable  = pc_enable;
  assign bus.regfile_we = regfile_we;

endmodule
